cpu_nios_pio_in: RTL and testbench
==================================

# cpu_nios_pio_in

Parametrised Avalon-MM input PIO for the Nios II system: it samples a WIDTH-bit external bus (switches, buttons, sensors), synchronises it, optionally debounces it, captures per-bit edges and raises a maskable interrupt. It sits on the Nios data master as a 4-word slave with fixed read latency 1. It supersedes the fixed 10-bit, data-only switch port.

## Interface
- WIDTH, 10: input bus width, 1..32.
- EDGE_TYPE, 0: edge captured per bit; 0 rising, 1 falling, 2 any.
- DEBOUNCE_CYCLES, 50000: stable cycles required before an input change is accepted; used only with debounce compiled in.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt to the Nios.

## Operation
- Register map: 0 DATA (RO, conditioned input), 1 reserved (reads 0, writes ignored), 2 IRQ_MASK (RW, WIDTH bits), 3 EDGE_CAPTURE (read; write-1-to-clear).
- Input path: 2-flop synchroniser s1→s2 per bit; conditioned value data_q = s2, or the debouncer output when debounce is compiled in; prev_q holds data_q from the previous cycle.
- Edge detect per bit: rising = data_q & ~prev_q; falling = ~data_q & prev_q; any = data_q ^ prev_q.
- EDGE_CAPTURE bit sets on a detected edge and holds until cleared. A write to address 3 clears the bits where writedata = 1. If a set and a clear hit the same bit in the same cycle, set wins.
- A write to address 2 loads IRQ_MASK from writedata[WIDTH-1:0].
- Writes occur when chipselect = 1 and write_n = 0. Writes to addresses 0 and 1 are ignored.
- irq = |(EDGE_CAPTURE & IRQ_MASK), driven combinationally from registers.
- readdata updates every cycle from the address mux, without chipselect gating. Bits [31:WIDTH] are always 0.
- Priming:
  - For the first 3 clock edges after reset deassertion, edge detection is disabled.
  - During this window, data_q loads s2 directly, bypassing the debouncer.
  - This prevents spurious captures from inputs that are already high.
- All registers reset to 0: s1, s2, data_q, prev_q, IRQ_MASK, EDGE_CAPTURE, debounce counters, priming counter. readdata and irq reset to 0.
- Reset assertion mid-operation clears all state immediately. Pending captures are lost.

## Timing
- in_port change sampled at edge k: s2 at k+1; data_q/prev comparison at k+2. EDGE_CAPTURE, irq and DATA-in-readdata all update at edge k+2. Debounce adds DEBOUNCE_CYCLES.
- Read latency is 1: the address presented at edge n appears on readdata after edge n+1.
- A write clearing EDGE_CAPTURE at edge n drops irq after edge n, provided no new edge arrives.
- Mask write at edge n affects irq after edge n.
- Pulses shorter than one clk period may be missed. This is accepted.

## Configuration
- CPU_NIOS_PIO_IN_DEBOUNCE_EN defined:
  - Each bit has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter resets whenever s2 equals data_q.
  - data_q takes s2 once the counter reaches DEBOUNCE_CYCLES.
- Undefined: data_q = s2 delayed one register. No counters are synthesised.

## Structure
- Package cpu_nios_pio_pkg holds:
  - ADDR_DATA = 0, ADDR_MASK = 2, ADDR_EDGE = 3.
  - Enum edge_type_e {EDGE_RISE, EDGE_FALL, EDGE_ANY}.
  - PRIME_CYCLES = 3.
- Sub-module cpu_nios_pio_debounce is a single-bit stable-count filter instantiated per bit in a generate loop, present only under the macro.

## Test plan
- Reset with in_port = 10'h3FF, then read DATA: readdata = 0x3FF after the priming window, EDGE_CAPTURE = 0, irq = 0.
- EDGE_TYPE = 0, mask = 0x001, drive bit0 0→1: EDGE_CAPTURE = 0x001 and irq = 1 three edges after the change. Drive bit0 1→0: no new capture.
- Write 0x001 to address 3 on the same cycle a new rising edge on bit0 reaches detection: bit stays set and irq stays 1. Clear again with no edge: irq = 0 the next cycle.
- Edge on bit5 with mask = 0: EDGE_CAPTURE = 0x020, irq = 0. Write mask = 0x020: irq = 1 the next cycle.
- With CPU_NIOS_PIO_IN_DEBOUNCE_EN and DEBOUNCE_CYCLES = 8, toggle bit2 every 4 cycles: DATA and EDGE_CAPTURE are unchanged. Hold bit2 high for 8 cycles: capture occurs.
- Assert reset_n low while irq = 1: irq, readdata and EDGE_CAPTURE are 0 immediately. Read address 1 after reset: readdata = 0.

Source files
------------

// File: rtl/cpu_nios_pio_pkg.sv
// Shared constants for the Nios II input PIO: register map, edge modes, priming length.
package cpu_nios_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    localparam int PRIME_CYCLES = 3;

endpackage

// File: rtl/cpu_nios_pio_debounce.sv
// Single-bit stable-count filter: accepts a new raw level only after it has
// differed from the current conditioned level for CYCLES consecutive cycles.
module cpu_nios_pio_debounce #(
    parameter int CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic prime,
    input  logic raw,
    input  logic cur,
    output logic filt
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          accept;

    assign accept = (raw != cur) && (count_reg == CW'(CYCLES));
    // While priming the raw level passes straight through so the filter starts in agreement.
    assign filt   = (prime || accept) ? raw : cur;

    always_comb begin
        count_next = count_reg + CW'(1);
        if (prime || (raw == cur) || accept) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/cpu_nios_pio_in.sv
// Avalon-MM input PIO with synchroniser, per-bit edge capture and maskable irq.
// Optional per-bit debounce is compiled in with CPU_NIOS_PIO_IN_DEBOUNCE_EN.
module cpu_nios_pio_in
    import cpu_nios_pio_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] s1_reg;
    logic [WIDTH-1:0] s2_reg;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] mask_next;
    logic [WIDTH-1:0] capture_reg;
    logic [WIDTH-1:0] capture_next;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] detect;
    logic [WIDTH-1:0] clear;
    logic [1:0]       prime_reg;
    logic             priming;
    logic             wr;
    logic [31:0]      readdata_next;

    assign priming = (prime_reg != 2'(PRIME_CYCLES));
    assign wr      = chipselect && !write_n;

`ifdef CPU_NIOS_PIO_IN_DEBOUNCE_EN
    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_debounce
        cpu_nios_pio_debounce #(
            .CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .prime   (priming),
            .raw     (s2_reg[gi]),
            .cur     (data_reg[gi]),
            .filt    (data_next[gi])
        );
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign data_next = s2_reg;
`endif

    // data_reg is the previous conditioned value, so captures land on the same
    // edge that the new value enters data_reg and the DATA read path.
    if (EDGE_TYPE == int'(EDGE_FALL)) begin : g_fall
        assign edge_raw = ~data_next & data_reg;
    end else if (EDGE_TYPE == int'(EDGE_ANY)) begin : g_any
        assign edge_raw = data_next ^ data_reg;
    end else begin : g_rise
        assign edge_raw = data_next & ~data_reg;
    end

    if (WIDTH < 32) begin : g_unused
        logic unused_writedata;
        assign unused_writedata = ^writedata[31:WIDTH];
    end

    assign detect = priming ? '0 : edge_raw;
    assign clear  = (wr && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

    // Set wins over a simultaneous clear of the same bit.
    assign capture_next = (capture_reg & ~clear) | detect;
    assign mask_next    = (wr && (address == ADDR_MASK)) ? writedata[WIDTH-1:0] : mask_reg;

    always_comb begin
        readdata_next = '0;
        case (address)
            ADDR_DATA: readdata_next[WIDTH-1:0] = data_next;
            ADDR_MASK: readdata_next[WIDTH-1:0] = mask_reg;
            ADDR_EDGE: readdata_next[WIDTH-1:0] = capture_reg;
            default:   readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_reg      <= '0;
            s2_reg      <= '0;
            data_reg    <= '0;
            mask_reg    <= '0;
            capture_reg <= '0;
            prime_reg   <= '0;
            readdata    <= '0;
        end else begin
            s1_reg      <= in_port;
            s2_reg      <= s1_reg;
            data_reg    <= data_next;
            mask_reg    <= mask_next;
            capture_reg <= capture_next;
            readdata    <= readdata_next;
            if (priming) begin
                prime_reg <= prime_reg + 2'd1;
            end
        end
    end

    assign irq = |(capture_reg & mask_reg);

endmodule

// File: tb/tb_cpu_nios_pio_in.sv
// Directed bench for cpu_nios_pio_in: vector table plus hand-written corner sequences.
module tb_cpu_nios_pio_in;

    localparam int WIDTH = 10;
`ifdef CPU_NIOS_PIO_IN_DEBOUNCE_EN
    localparam int DB     = 8;
    localparam int SETTLE = DB + 8;
`else
    localparam int DB     = 50000;
    localparam int SETTLE = 4;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    cpu_nios_pio_in #(
        .WIDTH(WIDTH),
        .EDGE_TYPE(0),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] in_val;
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] exp_cap;
        logic             exp_irq;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        d          = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;

        vecs[0] = '{10'h3FE, 10'h001, 10'h000, 1'b0};
        vecs[1] = '{10'h3FF, 10'h001, 10'h001, 1'b1};
        vecs[2] = '{10'h000, 10'h001, 10'h000, 1'b0};
        vecs[3] = '{10'h020, 10'h000, 10'h020, 1'b0};
        vecs[4] = '{10'h0A5, 10'h080, 10'h085, 1'b1};
        vecs[5] = '{10'h2AA, 10'h100, 10'h20A, 1'b0};
        vecs[6] = '{10'h155, 10'h3FF, 10'h155, 1'b1};

        reset_n    = 1'b0;
        in_port    = 10'h3FF;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        #1;
        check("reset_irq", irq, 0);
        check("reset_readdata", readdata, 0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        check("prime_irq", irq, 0);
        repeat (4) tick();
        bus_read(2'd0, rd);
        check("prime_data", rd, 32'h3FF);
        bus_read(2'd3, rd);
        check("prime_capture", rd, 0);
        check("prime_irq_after", irq, 0);

        for (int i = 0; i < 7; i++) begin
            bus_write(2'd2, 32'(vecs[i].mask));
            bus_write(2'd3, 32'h3FF);
            in_port = vecs[i].in_val;
            repeat (SETTLE) tick();
            check($sformatf("vec%0d_irq", i), irq, 32'(vecs[i].exp_irq));
            bus_read(2'd3, rd);
            check($sformatf("vec%0d_capture", i), rd, 32'(vecs[i].exp_cap));
            bus_read(2'd0, rd);
            check($sformatf("vec%0d_data", i), rd, 32'(vecs[i].in_val));
            bus_read(2'd2, rd);
            check($sformatf("vec%0d_mask", i), rd, 32'(vecs[i].mask));
        end

`ifndef CPU_NIOS_PIO_IN_DEBOUNCE_EN
        // Clear lands on the exact edge a new rising edge on bit0 is captured.
        in_port = 10'h154;
        repeat (4) tick();
        bus_write(2'd3, 32'h3FF);
        bus_write(2'd2, 32'h001);
        in_port = 10'h155;
        tick();
        tick();
        check("latency_before_capture", irq, 0);
        bus_write(2'd3, 32'h001);
        check("set_wins_irq", irq, 1);
        bus_read(2'd3, rd);
        check("set_wins_capture", rd, 32'h001);
        bus_write(2'd3, 32'h001);
        check("clear_irq", irq, 0);
        bus_read(2'd3, rd);
        check("clear_capture", rd, 0);
`endif

        bus_write(2'd2, 32'h000);
        bus_write(2'd3, 32'h3FF);
        in_port = 10'h175;
        repeat (SETTLE) tick();
        bus_read(2'd3, rd);
        check("masked_capture", rd, 32'h020);
        check("masked_irq", irq, 0);
        bus_write(2'd2, 32'h020);
        check("unmask_irq", irq, 1);

        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_irq", irq, 0);
        check("midreset_readdata", readdata, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) tick();
        bus_read(2'd3, rd);
        check("post_reset_capture", rd, 0);
        check("post_reset_irq", irq, 0);
        bus_read(2'd2, rd);
        check("post_reset_mask", rd, 0);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1, rd);
        check("reserved_read", rd, 0);

`ifdef CPU_NIOS_PIO_IN_DEBOUNCE_EN
        in_port = 10'h171;
        repeat (SETTLE) tick();
        bus_write(2'd3, 32'h3FF);
        for (int t = 0; t < 6; t++) begin
            in_port = in_port ^ 10'h004;
            repeat (4) tick();
        end
        bus_read(2'd0, rd);
        check("bounce_data", rd, 32'h171);
        bus_read(2'd3, rd);
        check("bounce_capture", rd, 0);
        in_port = 10'h175;
        repeat (SETTLE) tick();
        bus_read(2'd3, rd);
        check("stable_capture", rd, 32'h004);
        bus_read(2'd0, rd);
        check("stable_data", rd, 32'h175);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
